pwm_oc_deadtime_monitor: RTL and testbench
==========================================

// Module: pwm_oc_deadtime_monitor
// PURPOSE
//  Receive-side checker for a complementary PWM pair (high/low drive, e.g. pad feedback).
//  Measures each dead interval, flags dead intervals shorter than a programmable minimum,
//  and flags shoot-through (both legs high). Sits per channel beside the deadtime generator
//  and feeds sticky status and an IRQ pulse to the register block.
// PARAMETERS
//  WIDTH        8  width of dead-interval counter, min-deadtime value and measurement outputs
//  SYNC_STAGES  2  input synchronizer depth on pwm_high_i/pwm_low_i; 0 = sample directly
// PORTS
//  clk_psc_i         in   1      prescaled clock
//  rst_n_i           in   1      reset, asynchronous, active-low
//  enable_i          in   1      monitor enable
//  update_event_i    in   1      loads dt_min_preload_i into the shadow register
//  dt_min_preload_i  in   WIDTH  minimum legal dead interval, in clk cycles
//  pwm_high_i        in   1      observed main leg
//  pwm_low_i         in   1      observed complementary leg
//  fault_clr_i       in   1      clears sticky faults (1-cycle pulse)
//  dt_rise_o         out  WIDTH  last dead count, low-off -> high-on
//  dt_fall_o         out  WIDTH  last dead count, high-off -> low-on
//  dt_valid_o        out  1      1-cycle pulse: dt_rise_o or dt_fall_o updated this cycle
//  dt_fault_o        out  1      sticky: a measured dead count < dt_min shadow
//  shoot_fault_o     out  1      sticky: both legs sampled high
//  fault_irq_o       out  1      1-cycle pulse on every cycle a fault event is detected
// BEHAVIOUR
//  - Reset: all outputs 0. dt_min shadow = 0, counter = 0, synchronizer flops = 0, FSM = IDLE.
//  - Sampling: the FSM acts on the synchronized samples H and L.
//    - Latency from an input edge to the FSM reaction is SYNC_STAGES cycles.
//    - dt_valid_o and fault_irq_o are registered outputs: they appear SYNC_STAGES+1 cycles
//      after the input edge.
//  - dt_min shadow:
//    - Loaded on update_event_i only.
//    - The value used is the one held in the shadow on the capture cycle.
//  - FSM states: IDLE, HIGH (H=1,L=0), LOW (H=0,L=1), DEAD_F (both 0, after HIGH),
//    DEAD_R (both 0, after LOW), OVL (both 1).
//  - IDLE: H only -> HIGH, L only -> LOW, both -> OVL, neither -> stay. No measurement is
//    made out of IDLE, so the first edge after enable is never measured.
//  - HIGH -> DEAD_F when both 0; counter <= 1.
//    HIGH -> LOW directly: capture 0 into dt_fall_o, dt_valid_o=1, compare against dt_min.
//  - LOW mirrors HIGH: it goes to DEAD_R, or on a direct transition captures 0 into dt_rise_o.
//  - DEAD_F/DEAD_R while both 0: counter <= counter+1, saturating at 2^WIDTH-1.
//  - DEAD_F exit:
//    - H=1 -> HIGH? No: DEAD_F exits to LOW when L=1. Capture counter into dt_fall_o,
//      pulse dt_valid_o, compare against dt_min.
//    - H=1 (return to the same leg, aborted edge) -> HIGH. No capture, no fault.
//  - DEAD_R exit: H=1 -> HIGH with capture into dt_rise_o; L=1 -> LOW with no capture.
//  - Min-deadtime compare: captured count < dt_min shadow (unsigned) => dt_fault event.
//    dt_min = 0 disables the check.
//  - Both legs sampled 1, from any state: shoot event, -> OVL.
//    - A shoot event is raised on the entry cycle only, not for every cycle held in OVL.
//    - OVL exits like IDLE once not both high. No measurement spans an overlap.
//  - Counter: cleared to 0 in every non-DEAD state. Captured value = number of sampled
//    cycles with both legs low.
//  - Sticky faults:
//    - Set on an event; cleared by fault_clr_i.
//    - An event in the same cycle as fault_clr_i wins (flag stays 1).
//    - fault_irq_o pulses for each event cycle, even if the flag is already set.
//  - enable_i=0:
//    - FSM forced to IDLE, counter 0, no events, no dt_valid_o.
//    - dt_*_o and sticky flags hold. The synchronizer keeps running.
//    - Deasserting enable_i mid-dead discards the partial count.
//  - Reset mid-operation: immediate return to the reset values above; the next measurement
//    requires a fresh IDLE -> active entry.
// TESTING
//  1. dt_min=2 loaded via update; H=1 5 cyc, both 0 3 cyc, L=1
//     -> dt_fall_o=3, one dt_valid_o pulse, no fault.
//  2. dt_min=2; L=1, both 0 1 cyc, H=1
//     -> dt_rise_o=1, dt_fault_o=1, fault_irq_o exactly 1 cycle.
//  3. H=1 then H=L=1 for 1 cyc, then L=1
//     -> shoot_fault_o=1, one irq pulse, no dt_valid_o.
//  4. WIDTH=4; H=1, both 0 20 cyc, L=1
//     -> dt_fall_o=15 (saturated). Separately, H=1, both 0 2 cyc, H=1 again -> no dt_valid_o.
//  5. fault_clr_i on the same cycle as a new dt_fault event
//     -> dt_fault_o stays 1; a clr alone next cycle -> 0.
//  6. rst_n_i asserted in the middle of DEAD_F, or enable_i dropped mid-dead
//     -> outputs per the rules above; the next edge is unmeasured; the edge after it
//     measures correctly.
```

Note: the DEAD_F exit rule reads as self-contradictory because of a drafting slip. The intended rule is: DEAD_F with L=1 -> LOW, capturing into dt_fall_o; DEAD_F with H=1 -> HIGH as an aborted edge, with no capture.

Source files
------------

// File: rtl/pwm_oc_deadtime_monitor.sv
// Dead-interval and shoot-through checker for one complementary PWM pair.
// Measures dead gaps between legs, flags short gaps and overlaps.
module pwm_oc_deadtime_monitor #(
    parameter int WIDTH       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk_psc_i,
    input  logic             rst_n_i,
    input  logic             enable_i,
    input  logic             update_event_i,
    input  logic [WIDTH-1:0] dt_min_preload_i,
    input  logic             pwm_high_i,
    input  logic             pwm_low_i,
    input  logic             fault_clr_i,
    output logic [WIDTH-1:0] dt_rise_o,
    output logic [WIDTH-1:0] dt_fall_o,
    output logic             dt_valid_o,
    output logic             dt_fault_o,
    output logic             shoot_fault_o,
    output logic             fault_irq_o
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [2:0] {
        IDLE,
        HIGH,
        LOW,
        DEAD_F,
        DEAD_R,
        OVL
    } state_t;

    logic             h;
    logic             l;
    state_t           state;
    logic [WIDTH-1:0] cnt;
    logic [WIDTH-1:0] cnt_inc;
    logic [WIDTH-1:0] dt_min;

    generate
        if (SYNC_STAGES == 0) begin : g_nosync
            assign h = pwm_high_i;
            assign l = pwm_low_i;
        end else begin : g_sync
            logic [SYNC_STAGES-1:0] sh;
            logic [SYNC_STAGES-1:0] sl;

            always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
                if (!rst_n_i) begin
                    sh <= '0;
                    sl <= '0;
                end else begin
                    sh[0] <= pwm_high_i;
                    sl[0] <= pwm_low_i;
                    for (int i = 1; i < SYNC_STAGES; i++) begin
                        sh[i] <= sh[i-1];
                        sl[i] <= sl[i-1];
                    end
                end
            end

            assign h = sh[SYNC_STAGES-1];
            assign l = sl[SYNC_STAGES-1];
        end
    endgenerate

    assign cnt_inc = (&cnt) ? cnt : cnt + ONE;

    // Later event assignments override the fault_clr_i clear, so an event wins.
    always_ff @(posedge clk_psc_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state         <= IDLE;
            cnt           <= '0;
            dt_min        <= '0;
            dt_rise_o     <= '0;
            dt_fall_o     <= '0;
            dt_valid_o    <= 1'b0;
            dt_fault_o    <= 1'b0;
            shoot_fault_o <= 1'b0;
            fault_irq_o   <= 1'b0;
        end else begin
            dt_valid_o  <= 1'b0;
            fault_irq_o <= 1'b0;
            cnt         <= '0;
            if (update_event_i) begin
                dt_min <= dt_min_preload_i;
            end
            if (fault_clr_i) begin
                dt_fault_o    <= 1'b0;
                shoot_fault_o <= 1'b0;
            end
            if (!enable_i) begin
                state <= IDLE;
            end else if (h && l) begin
                state <= OVL;
                if (state != OVL) begin
                    shoot_fault_o <= 1'b1;
                    fault_irq_o   <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE, OVL: begin
                        if (h) begin
                            state <= HIGH;
                        end else if (l) begin
                            state <= LOW;
                        end else begin
                            state <= IDLE;
                        end
                    end
                    HIGH: begin
                        if (l) begin
                            state      <= LOW;
                            dt_fall_o  <= '0;
                            dt_valid_o <= 1'b1;
                            if (dt_min != '0) begin
                                dt_fault_o  <= 1'b1;
                                fault_irq_o <= 1'b1;
                            end
                        end else if (!h) begin
                            state <= DEAD_F;
                            cnt   <= ONE;
                        end
                    end
                    LOW: begin
                        if (h) begin
                            state      <= HIGH;
                            dt_rise_o  <= '0;
                            dt_valid_o <= 1'b1;
                            if (dt_min != '0) begin
                                dt_fault_o  <= 1'b1;
                                fault_irq_o <= 1'b1;
                            end
                        end else if (!l) begin
                            state <= DEAD_R;
                            cnt   <= ONE;
                        end
                    end
                    DEAD_F: begin
                        if (l) begin
                            state      <= LOW;
                            dt_fall_o  <= cnt;
                            dt_valid_o <= 1'b1;
                            if (cnt < dt_min) begin
                                dt_fault_o  <= 1'b1;
                                fault_irq_o <= 1'b1;
                            end
                        end else if (h) begin
                            state <= HIGH;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    DEAD_R: begin
                        if (h) begin
                            state      <= HIGH;
                            dt_rise_o  <= cnt;
                            dt_valid_o <= 1'b1;
                            if (cnt < dt_min) begin
                                dt_fault_o  <= 1'b1;
                                fault_irq_o <= 1'b1;
                            end
                        end else if (l) begin
                            state <= LOW;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_oc_deadtime_monitor.sv
// Randomised and directed bench for pwm_oc_deadtime_monitor.
// Reference model tracks legs and dead-run lengths directly.
module tb_pwm_oc_deadtime_monitor;

    localparam int W    = 4;
    localparam int S    = 2;
    localparam int MAXV = (1 << W) - 1;

    logic         clk   = 1'b0;
    logic         rst_n = 1'b0;
    logic         en    = 1'b0;
    logic         upd   = 1'b0;
    logic [W-1:0] pre   = '0;
    logic         h_in  = 1'b0;
    logic         l_in  = 1'b0;
    logic         clr   = 1'b0;
    logic [W-1:0] dt_rise;
    logic [W-1:0] dt_fall;
    logic         dt_valid;
    logic         dt_fault;
    logic         shoot;
    logic         irq;

    pwm_oc_deadtime_monitor #(
        .WIDTH       (W),
        .SYNC_STAGES (S)
    ) dut (
        .clk_psc_i        (clk),
        .rst_n_i          (rst_n),
        .enable_i         (en),
        .update_event_i   (upd),
        .dt_min_preload_i (pre),
        .pwm_high_i       (h_in),
        .pwm_low_i        (l_in),
        .fault_clr_i      (clr),
        .dt_rise_o        (dt_rise),
        .dt_fall_o        (dt_fall),
        .dt_valid_o       (dt_valid),
        .dt_fault_o       (dt_fault),
        .shoot_fault_o    (shoot),
        .fault_irq_o      (irq)
    );

    always #5 clk = ~clk;

    int nvec = 0;
    int nerr = 0;

    // model: cur = last leg seen (0 none, 1 high, 2 low, 3 both)
    bit           ph[S];
    bit           pl[S];
    int           cur;
    bit           dead;
    int           run;
    logic [W-1:0] m_rise;
    logic [W-1:0] m_fall;
    logic [W-1:0] m_min;
    bit           m_valid;
    bit           m_dtf;
    bit           m_sh;
    bit           m_irq;
    int           dv_cnt;
    int           di_cnt;

    function automatic void m_reset();
        for (int i = 0; i < S; i++) begin
            ph[i] = 1'b0;
            pl[i] = 1'b0;
        end
        cur     = 0;
        dead    = 1'b0;
        run     = 0;
        m_rise  = '0;
        m_fall  = '0;
        m_min   = '0;
        m_valid = 1'b0;
        m_dtf   = 1'b0;
        m_sh    = 1'b0;
        m_irq   = 1'b0;
    endfunction

    function automatic void m_step();
        bit sh;
        bit sl;
        bit ev_dt;
        bit ev_sh;
        int nw;
        int v;
        if (!rst_n) begin
            m_reset();
            return;
        end
        ev_dt = 1'b0;
        ev_sh = 1'b0;
        sh = ph[S-1];
        sl = pl[S-1];
        for (int i = S - 1; i > 0; i--) begin
            ph[i] = ph[i-1];
            pl[i] = pl[i-1];
        end
        ph[0] = h_in;
        pl[0] = l_in;
        m_valid = 1'b0;
        if (!en) begin
            cur  = 0;
            dead = 1'b0;
            run  = 0;
        end else if (sh && sl) begin
            if (cur != 3) ev_sh = 1'b1;
            cur  = 3;
            dead = 1'b0;
        end else if (!sh && !sl) begin
            if (dead) run++;
            else if (cur == 1 || cur == 2) begin
                dead = 1'b1;
                run  = 1;
            end else cur = 0;
        end else begin
            nw = sh ? 1 : 2;
            v  = -1;
            if (dead) begin
                if (nw != cur) v = run;
                dead = 1'b0;
            end else if ((cur == 1 || cur == 2) && cur != nw) begin
                v = 0;
            end
            if (v >= 0) begin
                if (v > MAXV) v = MAXV;
                if (nw == 2) m_fall = W'(v);
                else m_rise = W'(v);
                m_valid = 1'b1;
                if (v < int'(m_min)) ev_dt = 1'b1;
            end
            cur = nw;
        end
        m_irq = ev_dt | ev_sh;
        m_dtf = ev_dt | (m_dtf & ~clr);
        m_sh  = ev_sh | (m_sh & ~clr);
        if (upd) m_min = pre;
    endfunction

    task automatic tick();
        @(posedge clk);
        m_step();
        @(negedge clk);
        if (dt_valid) dv_cnt++;
        if (irq) di_cnt++;
    endtask

    task automatic drive(input bit h, input bit l, input int n);
        h_in = h;
        l_in = l;
        repeat (n) tick();
    endtask

    task automatic zero_counts();
        dv_cnt = 0;
        di_cnt = 0;
    endtask

    task automatic load_min(input int v);
        pre = W'(v);
        upd = 1'b1;
        tick();
        upd = 1'b0;
    endtask

    task automatic test_reset();
        m_reset();
        #1;
        nvec++;
        if (dt_rise !== '0) begin
            nerr++;
            $display("FAIL reset_rise: got %0d want 0", dt_rise);
        end
        nvec++;
        if (dt_fall !== '0) begin
            nerr++;
            $display("FAIL reset_fall: got %0d want 0", dt_fall);
        end
        nvec++;
        if ({dt_valid, dt_fault, shoot, irq} !== 4'b0) begin
            nerr++;
            $display("FAIL reset_flags: got %b want 0000",
                     {dt_valid, dt_fault, shoot, irq});
        end
        repeat (2) tick();
        rst_n = 1'b1;
    endtask

    task automatic test_dt_normal();
        load_min(2);
        en = 1'b1;
        zero_counts();
        drive(1, 0, 5);
        drive(0, 0, 3);
        drive(0, 1, 5);
        nvec++;
        if (dt_fall !== 4'd3) begin
            nerr++;
            $display("FAIL normal_fall: got %0d want 3", dt_fall);
        end
        nvec++;
        if (dv_cnt != 1 || dt_fault !== 1'b0) begin
            nerr++;
            $display("FAIL normal_valid: pulses %0d fault %b want 1 0",
                     dv_cnt, dt_fault);
        end
    endtask

    task automatic test_dt_short();
        zero_counts();
        drive(0, 0, 1);
        drive(1, 0, 5);
        nvec++;
        if (dt_rise !== 4'd1) begin
            nerr++;
            $display("FAIL short_rise: got %0d want 1", dt_rise);
        end
        nvec++;
        if (dt_fault !== 1'b1 || di_cnt != 1) begin
            nerr++;
            $display("FAIL short_fault: fault %b irqs %0d want 1 1",
                     dt_fault, di_cnt);
        end
    endtask

    task automatic test_shoot();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        zero_counts();
        drive(1, 1, 1);
        drive(0, 1, 5);
        nvec++;
        if (shoot !== 1'b1 || dt_fault !== 1'b0) begin
            nerr++;
            $display("FAIL shoot_flag: shoot %b dtf %b want 1 0",
                     shoot, dt_fault);
        end
        nvec++;
        if (di_cnt != 1 || dv_cnt != 0) begin
            nerr++;
            $display("FAIL shoot_pulses: irqs %0d valids %0d want 1 0",
                     di_cnt, dv_cnt);
        end
    endtask

    task automatic test_saturate();
        drive(0, 0, 2);
        drive(1, 0, 4);
        zero_counts();
        drive(0, 0, 20);
        drive(0, 1, 5);
        nvec++;
        if (dt_fall !== W'(MAXV) || dv_cnt != 1) begin
            nerr++;
            $display("FAIL sat_fall: got %0d/%0d want %0d/1",
                     dt_fall, dv_cnt, MAXV);
        end
        drive(0, 0, 3);
        drive(1, 0, 4);
        zero_counts();
        drive(0, 0, 2);
        drive(1, 0, 5);
        nvec++;
        if (dv_cnt != 0 || dt_rise !== 4'd3) begin
            nerr++;
            $display("FAIL abort_edge: valids %0d rise %0d want 0 3",
                     dv_cnt, dt_rise);
        end
    endtask

    task automatic test_clr_collision();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        nvec++;
        if (dt_fault !== 1'b0 || shoot !== 1'b0) begin
            nerr++;
            $display("FAIL clr_plain: dtf %b sh %b want 0 0", dt_fault, shoot);
        end
        drive(0, 0, 1);
        drive(0, 1, 2);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        nvec++;
        if (dt_fault !== 1'b1 || irq !== 1'b1 || dt_fall !== 4'd1) begin
            nerr++;
            $display("FAIL clr_collide: dtf %b irq %b fall %0d want 1 1 1",
                     dt_fault, irq, dt_fall);
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        nvec++;
        if (dt_fault !== 1'b0) begin
            nerr++;
            $display("FAIL clr_after: got %b want 0", dt_fault);
        end
    endtask

    task automatic test_reset_mid();
        drive(0, 0, 2);
        drive(1, 0, 4);
        drive(0, 0, 3);
        rst_n = 1'b0;
        m_reset();
        #1;
        nvec++;
        if (dt_rise !== '0 || dt_fall !== '0 ||
            {dt_valid, dt_fault, shoot, irq} !== 4'b0) begin
            nerr++;
            $display("FAIL rst_mid: rise %0d fall %0d flags %b want 0 0 0000",
                     dt_rise, dt_fall, {dt_valid, dt_fault, shoot, irq});
        end
        repeat (2) tick();
        rst_n = 1'b1;
        load_min(2);
        zero_counts();
        drive(0, 0, 2);
        drive(0, 1, 4);
        nvec++;
        if (dv_cnt != 0) begin
            nerr++;
            $display("FAIL rst_first_edge: valids %0d want 0", dv_cnt);
        end
        drive(0, 0, 3);
        drive(1, 0, 5);
        nvec++;
        if (dv_cnt != 1 || dt_rise !== 4'd3) begin
            nerr++;
            $display("FAIL rst_second_edge: valids %0d rise %0d want 1 3",
                     dv_cnt, dt_rise);
        end
    endtask

    task automatic test_enable_drop();
        zero_counts();
        drive(0, 0, 2);
        en = 1'b0;
        drive(0, 0, 2);
        en = 1'b1;
        drive(0, 1, 4);
        nvec++;
        if (dv_cnt != 0 || dt_fall !== '0) begin
            nerr++;
            $display("FAIL en_first_edge: valids %0d fall %0d want 0 0",
                     dv_cnt, dt_fall);
        end
        drive(0, 0, 4);
        drive(1, 0, 5);
        nvec++;
        if (dv_cnt != 1 || dt_rise !== 4'd4) begin
            nerr++;
            $display("FAIL en_second_edge: valids %0d rise %0d want 1 4",
                     dv_cnt, dt_rise);
        end
    endtask

    task automatic test_random();
        int seg;
        int pat;
        int len;
        for (seg = 0; seg < 250; seg++) begin
            pat = $urandom_range(0, 3);
            if (pat == 3 && $urandom_range(0, 3) != 0) pat = 0;
            len = $urandom_range(1, 20);
            h_in = (pat == 1 || pat == 3);
            l_in = (pat == 2 || pat == 3);
            en   = ($urandom_range(0, 15) != 0);
            for (int k = 0; k < len; k++) begin
                upd = ($urandom_range(0, 15) == 0);
                pre = W'($urandom_range(0, 6));
                clr = ($urandom_range(0, 19) == 0);
                tick();
                nvec++;
                if (dt_rise !== m_rise || dt_fall !== m_fall) begin
                    nerr++;
                    $display("FAIL rnd_meas: rise %0d fall %0d want %0d %0d",
                             dt_rise, dt_fall, m_rise, m_fall);
                end
                nvec++;
                if (dt_valid !== m_valid || irq !== m_irq) begin
                    nerr++;
                    $display("FAIL rnd_pulse: valid %b irq %b want %b %b",
                             dt_valid, irq, m_valid, m_irq);
                end
                nvec++;
                if (dt_fault !== m_dtf || shoot !== m_sh) begin
                    nerr++;
                    $display("FAIL rnd_sticky: dtf %b sh %b want %b %b",
                             dt_fault, shoot, m_dtf, m_sh);
                end
            end
        end
        upd = 1'b0;
        clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_dt_normal();
        test_dt_short();
        test_shoot();
        test_saturate();
        test_clr_collision();
        test_reset_mid();
        test_enable_drop();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
